bram_scale_ctrl: RTL

- Sequencer for the shared 1024x8 dual-port BRAM. Runs one block operation per start: reads LEN signed bytes from SRC on port A, scales each one, and writes the results to DST on port B.
- Result per element: y = sat8((x * gain) >>> shift).
- Sits between the control/register layer (start/busy/done handshake) and the BRAM ports. It owns both ports while busy.

---
 rtl/bram_scale_ctrl_pkg.sv | 26 ++
 rtl/bram_scale_ctrl_scale_sat8.sv | 52 +++++
 rtl/bram_scale_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bram_scale_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_scale_ctrl_pkg
// Description : Shared definitions for the BRAM block-scale sequencer:
//               default widths, saturation bounds and the controller state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_scale_ctrl_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 11;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bram_scale_ctrl_scale_sat8.sv
`default_nettype none
// ============================================================================
// Module      : scale_sat8
// Description : Combinational signed multiply, arithmetic right shift and
//               clamp to the signed sample range.
// Revision    : 1.0 - initial release
// Ports       : x     in  DATA_W  signed sample
//               gain  in  DATA_W  signed multiplier
//               shift in  3       arithmetic right-shift amount
//               y     out DATA_W  clamped result
//               sat   out 1       result was clamped
// ============================================================================
module scale_sat8
  import bram_scale_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] gain,
  input  logic [2:0]        shift,
  output logic [DATA_W-1:0] y,
  output logic              sat
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW-1:0] c_hi = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] c_lo = PW'(SAT_MIN);

  logic signed [PW-1:0] w_x;
  logic signed [PW-1:0] w_g;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shr;

  always_comb begin
    // Sign-extend explicitly so the product is a true full-width signed one.
    w_x    = {{DATA_W{x[DATA_W-1]}}, x};
    w_g    = {{DATA_W{gain[DATA_W-1]}}, gain};
    w_prod = w_x * w_g;
    w_shr  = w_prod >>> shift;
    sat    = 1'b0;
    y      = w_shr[DATA_W-1:0];
    if (w_shr > c_hi) begin
      y   = c_hi[DATA_W-1:0];
      sat = 1'b1;
    end else if (w_shr < c_lo) begin
      y   = c_lo[DATA_W-1:0];
      sat = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_scale_ctrl
// Description : Block sequencer for a shared dual-port BRAM. Reads LEN signed
//               samples from SRC on port A, scales/saturates each one and
//               writes them to DST on port B at one element per cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, rst              clock, synchronous active-high reset
//               start, abort          operation request / cancel
//               cfg_src/dst/len       block addresses and element count
//               cfg_gain/shift        scale factor and right shift
//               busy, done, aborted   status (done/aborted are pulses)
//               sat_count             clamped elements of the last operation
//               bram_*_a              read port (dout has 1-cycle latency)
//               bram_*_b              write port
// ============================================================================
module bram_scale_ctrl
  import bram_scale_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_gain,
  input  logic [2:0]        cfg_shift,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  sat_count,
  output logic [ADDR_W-1:0] bram_addr_a,
  output logic              bram_we_a,
  output logic [DATA_W-1:0] bram_din_a,
  input  logic [DATA_W-1:0] bram_dout_a,
  output logic [ADDR_W-1:0] bram_addr_b,
  output logic              bram_we_b,
  output logic [DATA_W-1:0] bram_din_b
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_abort;
  logic              w_last;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_k;
  logic [DATA_W-1:0] r_gain;
  logic [2:0]        r_shift;
  logic [ADDR_W-1:0] r_wptr;
  logic              r_rd_vld;   // bram_dout_a carries a live element this cycle

  logic [DATA_W-1:0] w_y;
  logic              w_sat;

  // Port A is read-only.
  assign bram_we_a  = 1'b0;
  assign bram_din_a = '0;

  scale_sat8 #(
    .DATA_W (DATA_W)
  ) u_scale (
    .x     (bram_dout_a),
    .gain  (r_gain),
    .shift (r_shift),
    .y     (w_y),
    .sat   (w_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = abort && (r_state != ST_IDLE);
    w_last      = (r_k == r_len - LEN_W'(1));
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (cfg_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN:   if (w_last) w_state_nxt = ST_DRAIN;
      // The last two writes retire during DRAIN and FIN.
      ST_DRAIN: w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      sat_count   <= '0;
      bram_addr_a <= '0;
      bram_addr_b <= '0;
      bram_we_b   <= 1'b0;
      bram_din_b  <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_gain      <= '0;
      r_shift     <= '0;
      r_wptr      <= '0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      busy      <= (w_state_nxt != ST_IDLE);
      done      <= (r_state == ST_FIN) && !w_abort;
      aborted   <= w_abort;
      r_rd_vld  <= (r_state == ST_RUN) && !w_abort;
      bram_we_b <= r_rd_vld && !w_abort;

      if (w_accept) begin
        r_len       <= cfg_len;
        r_gain      <= cfg_gain;
        r_shift     <= cfg_shift;
        r_wptr      <= cfg_dst;
        bram_addr_a <= cfg_src;
        r_k         <= '0;
        sat_count   <= '0;
      end else if ((r_state == ST_RUN) && !w_last) begin
        bram_addr_a <= bram_addr_a + 1'b1;
        r_k         <= r_k + 1'b1;
      end

      // Result register doubles as the port B output stage.
      if (r_rd_vld && !w_abort) begin
        bram_addr_b <= r_wptr;
        bram_din_b  <= w_y;
        r_wptr      <= r_wptr + 1'b1;
        if (w_sat && (sat_count != {LEN_W{1'b1}})) begin
          sat_count <= sat_count + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
